// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the cache/main-memory port arbiter: widths, state encodings,
// grant identifiers and the round-robin tie-break helper.
package mem_port_arbiter_pkg;

  localparam int ADDR_W  = 28;
  localparam int BLOCK_W = 128;
  localparam int TIMEOUT = 255;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_I_ISSUE = 3'd1;
  localparam logic [2:0] ST_I_WAIT  = 3'd2;
  localparam logic [2:0] ST_D_ISSUE = 3'd3;
  localparam logic [2:0] ST_D_WAIT  = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    I_ISSUE = ST_I_ISSUE,
    I_WAIT  = ST_I_WAIT,
    D_ISSUE = ST_D_ISSUE,
    D_WAIT  = ST_D_WAIT,
    DONE    = ST_DONE
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  // On a tie the side that was not served last wins.
  function automatic logic pick_side(input logic i_req, input logic d_req, input logic last_grant);
    if (i_req && !d_req) return GRANT_I;
    if (d_req && !i_req) return GRANT_D;
    return (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of icache, dcache and main-memory block-port signals seen by the arbiter.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic               i_read;
  logic [ADDR_W-1:0]  i_address;
  logic [BLOCK_W-1:0] i_readdata;
  logic               i_busywait;

  logic               d_read;
  logic               d_write;
  logic [ADDR_W-1:0]  d_address;
  logic [BLOCK_W-1:0] d_writedata;
  logic [BLOCK_W-1:0] d_readdata;
  logic               d_busywait;

  logic               mem_read;
  logic               mem_write;
  logic [ADDR_W-1:0]  mem_address;
  logic [BLOCK_W-1:0] mem_writedata;
  logic [BLOCK_W-1:0] mem_readdata;
  logic               mem_busywait;

  modport master (
    input  i_read, i_address, d_read, d_write, d_address, d_writedata,
           mem_readdata, mem_busywait,
    output i_readdata, i_busywait, d_readdata, d_busywait,
           mem_read, mem_write, mem_address, mem_writedata
  );

  modport slave (
    output i_read, i_address, d_read, d_write, d_address, d_writedata,
           mem_readdata, mem_busywait,
    input  i_readdata, i_busywait, d_readdata, d_busywait,
           mem_read, mem_write, mem_address, mem_writedata
  );

endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Counts busy cycles of a memory access and pulses expire on the last allowed one.
module mem_port_arbiter_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Expiry lands on the TIMEOUT-th busy cycle, so the count never wraps.
  assign expire = tick && (count == LAST);

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && !expire) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the main-memory block port between icache and dcache
// miss controllers, with a sticky watchdog flag for a memory that never answers.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  mem_port_arbiter_if.master  bus,
  output logic                err_timeout
);

  state_t state, next_state;
  logic   grant, last_grant, start_side;
  logic   start, finish_ok, finish_timeout;
  logic   i_req, d_req, in_issue, in_wait, expire;

  assign i_req      = bus.i_read;
  assign d_req      = bus.d_read | bus.d_write;
  assign in_issue   = (state == I_ISSUE) || (state == D_ISSUE);
  assign in_wait    = (state == I_WAIT) || (state == D_WAIT);
  assign start_side = pick_side(i_req, d_req, last_grant);

  assign bus.i_busywait = i_req & ~((state == DONE) && (grant == GRANT_I));
  assign bus.d_busywait = d_req & ~((state == DONE) && (grant == GRANT_D));

  mem_port_arbiter_watchdog #(.TIMEOUT(TIMEOUT)) watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (in_issue),
    .tick   (in_wait && bus.mem_busywait),
    .expire (expire)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state     = state;
    start          = 1'b0;
    finish_ok      = 1'b0;
    finish_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          start      = 1'b1;
          next_state = (start_side == GRANT_I) ? I_ISSUE : D_ISSUE;
        end
      end
      I_ISSUE: next_state = I_WAIT;
      D_ISSUE: next_state = D_WAIT;
      I_WAIT, D_WAIT: begin
        if (!bus.mem_busywait) begin
          finish_ok  = 1'b1;
          next_state = DONE;
        end else if (expire) begin
          finish_timeout = 1'b1;
          next_state     = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Memory-side outputs are loaded from the requester at grant time and then held,
  // so a requester changing its inputs mid-access cannot disturb memory.
  always_ff @(posedge clock) begin
    if (!reset) begin
      grant             <= GRANT_I;
      last_grant        <= GRANT_D;
      bus.mem_read      <= 1'b0;
      bus.mem_write     <= 1'b0;
      bus.mem_address   <= '0;
      bus.mem_writedata <= '0;
      bus.i_readdata    <= '0;
      bus.d_readdata    <= '0;
      err_timeout       <= 1'b0;
    end else begin
      if (start) begin
        grant <= start_side;
        if (start_side == GRANT_I) begin
          bus.mem_read      <= 1'b1;
          bus.mem_write     <= 1'b0;
          bus.mem_address   <= bus.i_address;
          bus.mem_writedata <= '0;
        end else begin
          bus.mem_read      <= ~bus.d_write;
          bus.mem_write     <= bus.d_write;
          bus.mem_address   <= bus.d_address;
          bus.mem_writedata <= bus.d_writedata;
        end
      end
      if (in_issue) last_grant <= grant;
      if (finish_ok) begin
        bus.mem_read  <= 1'b0;
        bus.mem_write <= 1'b0;
        if (bus.mem_read) begin
          if (grant == GRANT_I) bus.i_readdata <= bus.mem_readdata;
          else                  bus.d_readdata <= bus.mem_readdata;
        end
      end
      if (finish_timeout) begin
        bus.mem_read      <= 1'b0;
        bus.mem_write     <= 1'b0;
        bus.mem_address   <= '0;
        bus.mem_writedata <= '0;
        err_timeout       <= 1'b1;
      end
    end
  end

endmodule
